alu32_cmd_seq: RTL and testbench
================================

// Module: alu32_cmd_seq
// PURPOSE
//  Command-side driver for the 32-bit combinational ALU (op/a/b in, result + c/n/z/v out).
//  Accepts register-to-register commands over a valid/ready handshake and reads operands from
//  an internal 8x32 register file. Drives the ALU ports, writes the result back and latches flags.
//  Sits between a host/testbench controller and an externally instantiated alu32.
// PARAMETERS
//  AW        3   register-file address width (2**AW registers, data width fixed at 32)
// PORTS
//  clk          in   1   rising-edge clock
//  reset_n      in   1   asynchronous active-low reset
//  cmd_valid    in   1   command present
//  cmd_ready    out  1   block can accept a command (high only in IDLE)
//  cmd_op       in   3   ALU op: 000 ~a,001 ~b,010 and,011 or,100 xor,101 xnor,110 add,111 sub
//  cmd_rd       in   AW  destination register
//  cmd_rs1      in   AW  source register -> ALU a
//  cmd_rs2      in   AW  source register -> ALU b
//  host_we      in   1   host register write enable
//  host_waddr   in   AW  host write address
//  host_wdata   in   32  host write data
//  host_raddr   in   AW  host read address
//  host_rdata   out  32  combinational read of rf[host_raddr]
//  alu_a        out  32  registered operand a to ALU
//  alu_b        out  32  registered operand b to ALU
//  alu_op       out  3   registered op to ALU
//  alu_result   in   32  ALU result
//  alu_c/n/z/v  in   1   ALU flags (4 separate 1-bit ports)
//  rsp_valid    out  1   one-cycle pulse: command complete
//  rsp_result   out  32  result of last completed command
//  flag_c/n/z/v out  1   flags of last completed command (4 separate 1-bit ports)
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE; all rf entries, alu_a/b/op, rsp_result, flags = 0.
//    rsp_valid = 0. Reset mid-command aborts it: no writeback, no rsp_valid.
//  - FSM IDLE -> EXEC -> DONE -> IDLE; cmd_ready = (state==IDLE).
//  - Accept edge T0 (IDLE & cmd_valid): alu_a<=rf[rs1], alu_b<=rf[rs2], alu_op<=op,
//    rd latched; -> EXEC. No accept: stay IDLE, ALU outputs hold.
//  - EXEC: ALU evaluates combinationally. Edge T1: rf[rd]<=alu_result, rsp_result<=alu_result,
//    flag_*<=alu_*; -> DONE.
//  - DONE: rsp_valid=1 for exactly this cycle; next edge -> IDLE.
//  - Latency: rsp_valid high 2 cycles after the accept edge; max 1 command per 3 cycles.
//  - cmd_* sampled only on the accept edge; cmd_valid held in EXEC/DONE is ignored until IDLE.
//  - Host write: permitted in any state. Same edge as T1 and same address -> writeback wins.
//    Host write on the accept edge is NOT visible to that command's operands (old value read).
//  - Flags latched for every op, unfiltered; c/v meaning for logic ops is whatever the ALU drives.
//  - All registered outputs other than rsp_valid/flags/result hold between commands.
// CONFIGURATION
//  ALU_CMD_IMM_EN defined: extra ports cmd_imm_sel (in,1) and cmd_imm (in,32); when
//    cmd_imm_sel=1 at accept, alu_b<=cmd_imm instead of rf[rs2]; otherwise identical.
//  Not defined: ports absent; alu_b always from rf[rs2].
// STRUCTURE
//  - Package alu32_pkg: op localparams OP_NOTA..OP_SUB (3-bit), FSM state encodings
//    S_IDLE/S_EXEC/S_DONE (2-bit), data width constant 32.
//  - One sub-module: alu32_regfile (2**AW x 32, async reset to 0, one write port with
//    writeback-over-host priority mux, two command read ports + one host read port).
//  - FSM, operand registers and response/flag registers live in the top.
// TESTING (bench connects alu32_cmd_seq to alu32)
//  1 Reset with cmd_valid=1 -> cmd_ready=1, rsp_valid=0, all outputs and host_rdata 0.
//  2 host writes r1=0x7FFFFFFF, r2=1; ADD rd=3 -> rsp_valid 2 cycles after accept,
//    rsp_result=0x80000000, n=1,v=1,z=0,c=0; host_raddr=3 reads 0x80000000.
//  3 SUB rd=4 rs1=2 rs2=2 -> rsp_result=0, z=1, c=1, n=0, v=0.
//  4 cmd_valid held high over 3 commands -> accepts spaced exactly 3 cycles;
//    cmd_ready low in EXEC/DONE.
//  5 host_we to r3 with 0xDEADBEEF on T1 of a command with rd=3 -> r3 = ALU result.
//  6 reset_n low during EXEC -> no rsp_valid, state IDLE, rf zero; with ALU_CMD_IMM_EN:
//    r1=0x12345678, AND imm_sel=1 imm=0xFFFF0000 -> 0x12340000.

Source files
------------

// File: rtl/alu32_pkg.sv
// Shared constants for the ALU command sequencer: op codes, FSM states, data width.
package alu32_pkg;

  localparam int DW = 32;

  localparam logic [2:0] OP_NOTA = 3'd0;
  localparam logic [2:0] OP_NOTB = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_ADD  = 3'd6;
  localparam logic [2:0] OP_SUB  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu32_regfile.sv
// 2**AW x 32 register file: async reset to zero, writeback beats a same-address host write,
// two command read ports and one host read port, all combinational.
module alu32_regfile
  import alu32_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          host_we,
  input  logic [AW-1:0] host_waddr,
  input  logic [DW-1:0] host_wdata,
  input  logic [AW-1:0] rs1_addr,
  output logic [DW-1:0] rs1_data,
  input  logic [AW-1:0] rs2_addr,
  output logic [DW-1:0] rs2_data,
  input  logic [AW-1:0] host_raddr,
  output logic [DW-1:0] host_rdata
);

  localparam int NREG = 2 ** AW;

  logic [DW-1:0] mem [NREG];

  // Per-entry select: a host write to a different address still lands alongside writeback.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wb_en && wb_addr == AW'(i))
          mem[i] <= wb_data;
        else if (host_we && host_waddr == AW'(i))
          mem[i] <= host_wdata;
      end
    end
  end

  assign rs1_data   = mem[rs1_addr];
  assign rs2_data   = mem[rs2_addr];
  assign host_rdata = mem[host_raddr];

endmodule

// File: rtl/alu32_cmd_seq.sv
// Command sequencer driving an external alu32: IDLE -> EXEC -> DONE, one command per 3 cycles.
// Optional immediate operand path enabled by defining ALU_CMD_IMM_EN.
module alu32_cmd_seq
  import alu32_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
`ifdef ALU_CMD_IMM_EN
  input  logic          cmd_imm_sel,
  input  logic [DW-1:0] cmd_imm,
`endif
  input  logic          host_we,
  input  logic [AW-1:0] host_waddr,
  input  logic [DW-1:0] host_wdata,
  input  logic [AW-1:0] host_raddr,
  output logic [DW-1:0] host_rdata,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_c,
  input  logic          alu_n,
  input  logic          alu_z,
  input  logic          alu_v,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_result,
  output logic          flag_c,
  output logic          flag_n,
  output logic          flag_z,
  output logic          flag_v
);

  state_t        state, state_nxt;
  logic [AW-1:0] rd_q;
  logic          accept, wb_en;
  logic [DW-1:0] rs1_data, rs2_data, b_sel;

  alu32_regfile #(.AW(AW)) u_rf (
    .clk        (clk),
    .reset_n    (reset_n),
    .wb_en      (wb_en),
    .wb_addr    (rd_q),
    .wb_data    (alu_result),
    .host_we    (host_we),
    .host_waddr (host_waddr),
    .host_wdata (host_wdata),
    .rs1_addr   (cmd_rs1),
    .rs1_data   (rs1_data),
    .rs2_addr   (cmd_rs2),
    .rs2_data   (rs2_data),
    .host_raddr (host_raddr),
    .host_rdata (host_rdata)
  );

`ifdef ALU_CMD_IMM_EN
  assign b_sel = cmd_imm_sel ? cmd_imm : rs2_data;
`else
  assign b_sel = rs2_data;
`endif

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    wb_en     = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        wb_en     = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operands are captured at accept so the ALU sees stable inputs for the whole EXEC cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      rd_q       <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= OP_NOTA;
      rsp_result <= '0;
      flag_c     <= 1'b0;
      flag_n     <= 1'b0;
      flag_z     <= 1'b0;
      flag_v     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_a  <= rs1_data;
        alu_b  <= b_sel;
        alu_op <= cmd_op;
        rd_q   <= cmd_rd;
      end
      if (wb_en) begin
        rsp_result <= alu_result;
        flag_c     <= alu_c;
        flag_n     <= alu_n;
        flag_z     <= alu_z;
        flag_v     <= alu_v;
      end
    end
  end

endmodule

// File: tb/tb_alu32_cmd_seq.sv
// Bench for alu32_cmd_seq with a behavioural alu32 stand-in and a cycle-level reference model.
module tb_alu32_cmd_seq;

  logic        clk, reset_n;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_rd, cmd_rs1, cmd_rs2;
  logic        cmd_imm_sel;
  logic [31:0] cmd_imm;
  logic        host_we;
  logic [2:0]  host_waddr, host_raddr;
  logic [31:0] host_wdata, host_rdata;
  logic [31:0] alu_a, alu_b, alu_result, rsp_result;
  logic [2:0]  alu_op;
  logic        alu_c, alu_n, alu_z, alu_v;
  logic        rsp_valid, flag_c, flag_n, flag_z, flag_v;

  int checks = 0;
  int failures = 0;

  alu32_cmd_seq #(.AW(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
`ifdef ALU_CMD_IMM_EN
    .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm),
`endif
    .host_we(host_we), .host_waddr(host_waddr), .host_wdata(host_wdata),
    .host_raddr(host_raddr), .host_rdata(host_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .flag_c(flag_c), .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {c, n, z, v, result}; c is carry-out for add and not-borrow for sub.
  function automatic logic [35:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; s = '0;
    case (op)
      3'd0: r = ~a;
      3'd1: r = ~b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~(a ^ b);
      3'd6: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      default: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
    endcase
    return {c, r[31], (r == 32'd0), v, r};
  endfunction

  always_comb {alu_c, alu_n, alu_z, alu_v, alu_result} = alu_f(alu_op, alu_a, alu_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: register array plus the cycle numbers at which each event becomes due.
  int          cyc = 0;
  int          free_at = 0, wb_at = -1, vld_at = -1;
  logic [31:0] mrf [8];
  logic [2:0]  p_rd;
  logic [35:0] p_out;
  logic [31:0] e_a, e_b, e_res;
  logic [2:0]  e_op;
  logic [3:0]  e_fl;
  int          acc_q[$];

  always @(negedge clk) begin
    logic [31:0] bop;
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) mrf[i] = '0;
      free_at = 0; wb_at = -1; vld_at = -1;
      e_a = '0; e_b = '0; e_op = '0; e_res = '0; e_fl = '0; p_rd = '0; p_out = '0;
    end
    chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, cyc >= free_at});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, cyc == vld_at});
    chk("rsp_result", rsp_result, e_res);
    chk("flags_cnzv", {28'd0, flag_c, flag_n, flag_z, flag_v}, {28'd0, e_fl});
    chk("alu_a", alu_a, e_a);
    chk("alu_b", alu_b, e_b);
    chk("alu_op", {29'd0, alu_op}, {29'd0, e_op});
    chk("host_rdata", host_rdata, mrf[host_raddr]);
    if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
    if (reset_n) begin
      if (cmd_valid && cyc >= free_at) begin
        bop = mrf[cmd_rs2];
`ifdef ALU_CMD_IMM_EN
        if (cmd_imm_sel) bop = cmd_imm;
`endif
        e_a = mrf[cmd_rs1]; e_b = bop; e_op = cmd_op;
        p_out = alu_f(cmd_op, e_a, e_b);
        p_rd = cmd_rd;
        wb_at = cyc + 1;
        free_at = cyc + 3;
      end
      if (host_we) mrf[host_waddr] = host_wdata;
      if (cyc == wb_at) begin
        mrf[p_rd] = p_out[31:0];
        e_res = p_out[31:0];
        e_fl = p_out[35:32];
        vld_at = cyc + 1;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [2:0] a, input logic [31:0] d);
    host_we = 1'b1; host_waddr = a; host_wdata = d;
    tick();
    host_we = 1'b0;
  endtask

  // Issues one command, waits for its response and checks the accept-to-response latency.
  task automatic run_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic isel, input logic [31:0] imm,
                         output logic [31:0] res, output logic [3:0] fl);
    int n;
    bit ok;
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_imm_sel = isel; cmd_imm = imm;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
    end
    tick();
    cmd_valid = 1'b0; cmd_imm_sel = 1'b0;
    n = 0; ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      n++;
      if (rsp_valid) ok = 1;
    end
    chk("rsp_latency", n, ok ? 32'd2 : 32'hFFFF_FFFF);
    res = rsp_result;
    fl = {flag_c, flag_n, flag_z, flag_v};
    tick();
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0]  f;
    bit          sp_ok;
    reset_n = 1'b0; cmd_valid = 1'b1; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
    cmd_imm_sel = 1'b0; cmd_imm = '0;
    host_we = 1'b0; host_waddr = '0; host_wdata = '0; host_raddr = '0;

    // Reset with a command pending
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_outputs", alu_a | alu_b | rsp_result | {29'd0, alu_op}, 32'd0);
    chk("rst_host_rdata", host_rdata, 32'd0);
    tick();
    cmd_valid = 1'b0;
    reset_n = 1'b1;
    tick();

    // Signed overflow on ADD
    host_write(3'd1, 32'h7FFF_FFFF);
    host_write(3'd2, 32'h0000_0001);
    run_cmd(3'd6, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0, r, f);
    chk("add_result", r, 32'h8000_0000);
    chk("add_flags_cnzv", {28'd0, f}, 32'b0101);
    host_raddr = 3'd3;
    #1 chk("add_rd_readback", host_rdata, 32'h8000_0000);

    // SUB to zero: no borrow, zero flag
    run_cmd(3'd7, 3'd4, 3'd2, 3'd2, 1'b0, 32'd0, r, f);
    chk("sub_result", r, 32'h0000_0000);
    chk("sub_flags_cnzv", {28'd0, f}, 32'b1010);

    // Back-to-back commands with cmd_valid held
    acc_q.delete();
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_rd = 3'd5; cmd_rs1 = 3'd1; cmd_rs2 = 3'd3;
    repeat (9) tick();
    cmd_valid = 1'b0;
    repeat (3) tick();
    chk("b2b_accepts", acc_q.size(), 32'd3);
    sp_ok = (acc_q.size() == 3) && (acc_q[1] - acc_q[0] == 3) && (acc_q[2] - acc_q[1] == 3);
    chk("b2b_spacing", {31'd0, sp_ok}, 32'd1);
    chk("b2b_r5", dut.u_rf.mem[5], 32'hFFFF_FFFF);

    // Host write colliding with writeback on the same register
    host_raddr = 3'd3;
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_rd = 3'd3; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
    tick();
    cmd_valid = 1'b0;
    host_write(3'd3, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("collide_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("collide_r3", host_rdata, 32'h7FFF_FFFF);
    tick();

    // Reset in the middle of EXEC aborts the command
    cmd_valid = 1'b1; cmd_op = 3'd6; cmd_rd = 3'd6; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
    tick();
    cmd_valid = 1'b0;
    reset_n = 1'b0;
    host_raddr = 3'd1;
    repeat (2) tick();
    reset_n = 1'b1;
    sp_ok = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) sp_ok = 0;
    end
    chk("abort_no_rsp", {31'd0, sp_ok}, 32'd1);
    chk("abort_rf_zero", host_rdata, 32'd0);
    chk("abort_idle", {31'd0, cmd_ready}, 32'd1);
    tick();

`ifdef ALU_CMD_IMM_EN
    host_write(3'd1, 32'h1234_5678);
    run_cmd(3'd2, 3'd6, 3'd1, 3'd0, 1'b1, 32'hFFFF_0000, r, f);
    chk("imm_and_result", r, 32'h1234_0000);
`endif

    // Logic op through the model on freshly written operands
    host_write(3'd1, 32'h0F0F_00FF);
    host_write(3'd2, 32'h00FF_0F0F);
    run_cmd(3'd5, 3'd7, 3'd1, 3'd2, 1'b0, 32'd0, r, f);
    chk("xnor_result", r, 32'hF00F_F00F);
    run_cmd(3'd0, 3'd0, 3'd1, 3'd2, 1'b0, 32'd0, r, f);
    chk("nota_result", r, 32'hF0F0_FF00);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
